cnn_window_fetcher: RTL and testbench
=====================================

// Module: cnn_window_fetcher
// PURPOSE
//  Consumer stage for the CNN memory's 25-word combinational read port.
//  Walks a stored feature map (row-major, 16-bit pixels) and assembles K x K sliding windows,
//  stride 1, in raster order. Each window takes K row reads; only the first K words of each read are used.
//  Presents each window to the convolution engine through a valid/ready handshake.
// PARAMETERS
//  DATA_W  16  pixel width
//  ADDR_W  16  CNN memory address width
//  K       5   window edge; window = K*K words
//  PORT_W  25  words returned per memory read (PORT_W >= K)
// PORTS
//  clk          in   1              clock, rising edge
//  rst_n        in   1              asynchronous reset, active low
//  start        in   1              1-cycle pulse; accepted only in IDLE
//  img_base     in   ADDR_W         address of pixel (0,0); latched on start
//  img_w        in   ADDR_W         image width in pixels; latched on start
//  img_h        in   ADDR_W         image height in pixels; latched on start
//  mem_addr     out  ADDR_W         read address driven to CNN memory
//  mem_rd_data  in   PORT_W*DATA_W  CNN memory data_out, combinational from mem_addr
//  mem_rd_active out 1              1 while the fetcher owns the memory address (arbitration with writer)
//  win_data     out  K*K*DATA_W     window; word r*K+c = pixel(row+r, col+c)
//  win_valid    out  1              window valid
//  win_ready    in   1              downstream accepts window
//  busy         out  1              1 from accepted start until done
//  done         out  1              1-cycle pulse at end of frame
//  err          out  1              set with done when img_w<K or img_h<K; cleared on next start
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; mem_addr=0, win_data=0, win_valid=0, busy=0, done=0, err=0, mem_rd_active=0.
//   Reset mid-frame aborts immediately; no partial window is ever presented.
//  FSM: IDLE -> FETCH -> OUT -> (FETCH | DONE) -> IDLE.
//  IDLE: on start, latch img_base/img_w/img_h; row=col=r=0; busy=1.
//   If img_w<K or img_h<K, go to DONE with err=1. Otherwise go to FETCH.
//  FETCH (K cycles): mem_rd_active=1; mem_addr = img_base + (row+r)*img_w + col.
//   Each edge captures mem_rd_data words [0..K-1] into window row r, then r++.
//   After the edge with r=K-1, go to OUT with win_valid=1.
//   First win_valid is seen K edges after the start edge.
//  OUT: win_data and win_valid held stable until win_ready=1; mem_rd_active=0.
//   On handshake, clear win_valid and advance:
//    - col<img_w-K: col++.
//    - else: col=0, row++.
//   If the accepted window was (row=img_h-K, col=img_w-K), go to DONE; else go to FETCH.
//  DONE: done=1 for exactly one cycle, busy=0, then IDLE.
//   A start in the DONE cycle is ignored.
//  Address arithmetic: no multiplier. Keep registered row_ptr = img_base + row*img_w and rd_ptr = row_ptr + r*img_w + col.
//   All adds are ADDR_W bits, wrap modulo 2^ADDR_W. Out-of-range addresses are a caller error.
//  start while busy: ignored; latched parameters do not change.
//  Window count = (img_h-K+1)*(img_w-K+1). Minimum K+1 cycles per window; no fetch overlaps OUT.
//  img_w == K or img_h == K are legal (single column or single row of windows).
// STRUCTURE
//  Shared package cnn_pkg:
//   - DATA_W, ADDR_W, K, PORT_W constants
//   - typedef word_t, addr_t, window_t (K*K array of word_t)
//   - enum fetch_state_t {IDLE, FETCH, OUT, DONE}
//  Sub-module cnn_addr_gen: row/col/r counters, row_ptr/rd_ptr accumulators, last-window flag.
//   Controlled by the FSM through step_r, step_win and load strobes.
//  Top module: FSM, window capture registers, handshake.
// TESTING
//  Memory model: mem[i]=i, combinational read of 25 words.
//  1. Nominal frame:
//   - Stimulus: img_base=100, img_w=8, img_h=6, win_ready=1.
//   - Response: 8 windows. First window: [0]=100, [4]=104, [5]=108, [24]=136.
//   - Last window: [0]=111, [24]=147. done pulses once; busy falls with done.
//  2. Backpressure:
//   - Stimulus: hold win_ready=0 for 10 cycles on window 3.
//   - Response: win_data/win_valid stable, mem_rd_active=0, no window lost or duplicated.
//  3. Degenerate size:
//   - Stimulus: img_w=4, img_h=9.
//   - Response: no win_valid; done=1 and err=1 within 2 cycles; next valid start clears err.
//  4. Exact fit:
//   - Stimulus: img_w=5, img_h=5, img_base=0.
//   - Response: exactly 1 window, data 0..4, 5..9, ... 20..24; then done.
//  5. Reset mid-FETCH:
//   - Stimulus: assert rst_n=0 at r=2.
//   - Response: all outputs 0 immediately.
//   - Then a new start with img_base=100, img_w=8, img_h=6 reproduces scenario 1 exactly.
//  6. Start while busy:
//   - Stimulus: pulse start with img_base=500 mid-frame.
//   - Response: ignored; windows still addressed from base 100.

Source files
------------

// File: rtl/cnn_window_fetcher_pkg.sv
// Shared types and constants for the CNN window fetcher slice.
package cnn_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int K      = 5;
  localparam int PORT_W = 25;
  localparam int R_W    = $clog2(K);

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [R_W-1:0]    ridx_t;
  // Word r*K+c of a window is pixel (row+r, col+c).
  typedef word_t [K*K-1:0]   window_t;

  typedef enum logic [1:0] {IDLE, FETCH, OUT, DONE} fetch_state_t;

  // A frame holds at least one window only if both dimensions reach K.
  function automatic logic frame_fits(addr_t w, addr_t h);
    return (w >= addr_t'(K)) && (h >= addr_t'(K));
  endfunction

endpackage

// File: rtl/cnn_window_fetcher_if.sv
// Memory read port and window handshake between fetcher and its neighbours.
interface cnn_window_fetcher_if;
  import cnn_pkg::*;

  addr_t                      mem_addr;
  logic [PORT_W*DATA_W-1:0]   mem_rd_data;
  logic                       mem_rd_active;
  window_t                    win_data;
  logic                       win_valid;
  logic                       win_ready;

  // Fetcher side: drives the address and presents windows.
  modport master (
    output mem_addr, mem_rd_active, win_data, win_valid,
    input  mem_rd_data, win_ready
  );

  // Memory / convolution-engine side.
  modport slave (
    input  mem_addr, mem_rd_active, win_data, win_valid,
    output mem_rd_data, win_ready
  );

endinterface

// File: rtl/cnn_window_fetcher_addr_gen.sv
// Window position counters and multiplier-free read address accumulators.
module cnn_addr_gen
  import cnn_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  logic  step_r,
  input  logic  step_win,
  input  addr_t img_base,
  input  addr_t img_w,
  input  addr_t img_h,
  output addr_t rd_ptr,
  output logic  last_r,
  output logic  last_win
);

  addr_t w_reg;
  addr_t h_reg;
  addr_t row_reg;
  addr_t col_reg;
  addr_t row_ptr_reg;
  addr_t rd_ptr_reg;
  ridx_t r_reg;
  addr_t col_lim;
  addr_t row_lim;

  // Last legal window origin along each axis.
  assign col_lim  = w_reg - addr_t'(K);
  assign row_lim  = h_reg - addr_t'(K);
  assign last_r   = (r_reg == ridx_t'(K - 1));
  assign last_win = (row_reg == row_lim) && (col_reg == col_lim);
  assign rd_ptr   = rd_ptr_reg;

  // row_ptr tracks base + row*w; rd_ptr walks down the window one image row per step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_reg       <= '0;
      h_reg       <= '0;
      row_reg     <= '0;
      col_reg     <= '0;
      row_ptr_reg <= '0;
      rd_ptr_reg  <= '0;
      r_reg       <= '0;
    end else if (load) begin
      w_reg       <= img_w;
      h_reg       <= img_h;
      row_reg     <= '0;
      col_reg     <= '0;
      row_ptr_reg <= img_base;
      rd_ptr_reg  <= img_base;
      r_reg       <= '0;
    end else if (step_r) begin
      if (last_r) begin
        r_reg <= '0;
      end else begin
        r_reg      <= r_reg + ridx_t'(1);
        rd_ptr_reg <= rd_ptr_reg + w_reg;
      end
    end else if (step_win) begin
      if (col_reg < col_lim) begin
        col_reg    <= col_reg + addr_t'(1);
        rd_ptr_reg <= row_ptr_reg + col_reg + addr_t'(1);
      end else begin
        col_reg     <= '0;
        row_reg     <= row_reg + addr_t'(1);
        row_ptr_reg <= row_ptr_reg + w_reg;
        rd_ptr_reg  <= row_ptr_reg + w_reg;
      end
    end
  end

endmodule

// File: rtl/cnn_window_fetcher.sv
// Assembles KxK sliding windows from the wide memory read port and hands them downstream.
module cnn_window_fetcher
  import cnn_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  addr_t                 img_base,
  input  addr_t                 img_w,
  input  addr_t                 img_h,
  cnn_window_fetcher_if.master  bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int ROW_BITS = K * DATA_W;
  localparam int WIN_BITS = K * K * DATA_W;

  fetch_state_t         state_reg;
  fetch_state_t         state_next;
  logic [WIN_BITS-1:0]  win_reg;
  logic                 err_reg;
  addr_t                rd_ptr;
  logic                 last_r;
  logic                 last_win;
  logic                 load;
  logic                 step_r;
  logic                 step_win;
  logic                 fits;
  logic                 unused_port_words;

  // Only the first K words of each read belong to the window.
  assign unused_port_words = ^bus.mem_rd_data[PORT_W*DATA_W-1:ROW_BITS];

  assign fits     = frame_fits(img_w, img_h);
  assign load     = (state_reg == IDLE) && start;
  assign step_r   = (state_reg == FETCH);
  assign step_win = (state_reg == OUT) && bus.win_ready;

  cnn_addr_gen u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .step_r   (step_r),
    .step_win (step_win),
    .img_base (img_base),
    .img_w    (img_w),
    .img_h    (img_h),
    .rd_ptr   (rd_ptr),
    .last_r   (last_r),
    .last_win (last_win)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic: a too-small frame skips straight to DONE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = fits ? FETCH : DONE;
      FETCH:   if (last_r) state_next = OUT;
      OUT:     if (bus.win_ready) state_next = last_win ? DONE : FETCH;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state; memory is only claimed while fetching.
  always_comb begin
    bus.mem_rd_active = (state_reg == FETCH);
    bus.win_valid     = (state_reg == OUT);
    busy              = (state_reg == FETCH) || (state_reg == OUT);
    done              = (state_reg == DONE);
  end

  // Error flag reflects the size check of the most recently accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    err_reg <= 1'b0;
    else if (load) err_reg <= ~fits;
  end

  // Rows shift in from the top, so after K fetches row 0 sits at the low words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      win_reg <= '0;
    else if (step_r) win_reg <= {bus.mem_rd_data[ROW_BITS-1:0], win_reg[WIN_BITS-1:ROW_BITS]};
  end

  assign bus.win_data = win_reg;
  assign bus.mem_addr = rd_ptr;
  assign err          = err_reg;

endmodule

// File: tb/tb_cnn_window_fetcher.sv
// Scoreboard bench: reference windows are queued at start, a monitor checks each handshake.
module tb_cnn_window_fetcher;
  import cnn_pkg::*;

  localparam int WIN_BITS = K * K * DATA_W;
  typedef logic [WIN_BITS-1:0] win_vec_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  start = 1'b0;
  addr_t img_base = '0;
  addr_t img_w = '0;
  addr_t img_h = '0;
  logic  busy, done, err;

  cnn_window_fetcher_if bus();

  cnn_window_fetcher dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .img_base (img_base),
    .img_w    (img_w),
    .img_h    (img_h),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Memory model: mem[i] = i, combinational wide read.
  for (genvar gj = 0; gj < PORT_W; gj++) begin : g_mem
    assign bus.mem_rd_data[gj*DATA_W +: DATA_W] = bus.mem_addr + addr_t'(gj);
  end

  win_vec_t sb_q[$];
  int       checks = 0;
  int       errors = 0;
  int       rx_cnt = 0;
  bit       exp_err = 1'b0;
  int       ready_mode = 0;
  int       stall_win = -1;
  int       stall_left = 0;
  bit       held = 1'b0;
  win_vec_t held_data;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Window at (row,col) straight from the pixel-address rule.
  function automatic win_vec_t ref_window(int base, int w, int row, int col);
    win_vec_t v;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        v[(r*K+c)*DATA_W +: DATA_W] = DATA_W'((base + (row + r) * w + col + c) & 16'hFFFF);
    return v;
  endfunction

  function automatic int n_windows(int w, int h);
    if (w < K || h < K) return 0;
    return (h - K + 1) * (w - K + 1);
  endfunction

  task automatic expect_frame(int base, int w, int h);
    exp_err = (w < K || h < K);
    if (!exp_err)
      for (int row = 0; row <= h - K; row++)
        for (int col = 0; col <= w - K; col++)
          sb_q.push_back(ref_window(base, w, row, col));
  endtask

  task automatic pulse_start(int base, int w, int h, bit model);
    @(posedge clk); #1;
    img_base = addr_t'(base);
    img_w    = addr_t'(w);
    img_h    = addr_t'(h);
    start    = 1'b1;
    if (model) begin
      rx_cnt = 0;
      expect_frame(base, w, h);
    end
    @(posedge clk); #1;
    start = 1'b0;
    if (model) begin
      chk("start_err", err, exp_err);
      chk("start_busy", busy, !exp_err);
      chk("start_done", done, exp_err);
    end
  endtask

  task automatic wait_done(int budget, string tag);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, seen, 1);
    if (seen) begin
      chk({tag, "_busy_at_done"}, busy, 0);
      chk({tag, "_err"}, err, exp_err);
      chk({tag, "_queue_left"}, sb_q.size(), 0);
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, done, 0);
    end
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_win_data"}, |bus.win_data, 0);
    chk({tag, "_win_valid"}, bus.win_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_rd_active"}, bus.mem_rd_active, 0);
  endtask

  // Ready driver: steady with an optional stall on one window, or random.
  initial begin
    bus.win_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (ready_mode == 1) begin
        bus.win_ready = ($urandom_range(0, 3) != 0);
      end else if (stall_left > 0 && rx_cnt == stall_win && bus.win_valid) begin
        bus.win_ready = 1'b0;
        stall_left--;
      end else begin
        bus.win_ready = 1'b1;
      end
    end
  end

  // Monitor: stability under backpressure and in-order window comparison.
  initial begin
    win_vec_t exp_w;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
      end else if (bus.win_valid) begin
        chk("rd_active_in_out", bus.mem_rd_active, 0);
        if (held) begin
          checks++;
          if (bus.win_data !== held_data) begin
            errors++;
            $display("FAIL win_stable: got %h expected %h", bus.win_data, held_data);
          end
        end
        if (bus.win_ready) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL win_unexpected: got %h expected none", bus.win_data);
          end else begin
            exp_w = sb_q.pop_front();
            if (bus.win_data !== exp_w) begin
              errors++;
              $display("FAIL win_%0d: got %h expected %h", rx_cnt, bus.win_data, exp_w);
            end
          end
          rx_cnt++;
          held = 1'b0;
        end else begin
          held      = 1'b1;
          held_data = bus.win_data;
        end
      end else if (held) begin
        chk("win_dropped", bus.win_valid, 1);
        held = 1'b0;
      end
    end
  end

  initial begin
    int w, h, base;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Nominal frame with first-window latency.
    pulse_start(100, 8, 6, 1);
    repeat (K - 1) @(posedge clk);
    @(negedge clk);
    chk("latency_before", bus.win_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk("latency_first", bus.win_valid, 1);
    wait_done(200, "nominal");
    chk("nominal_count", rx_cnt, 8);

    // Backpressure: third window stalled for 10 cycles.
    stall_win  = 2;
    stall_left = 10;
    pulse_start(100, 8, 6, 1);
    wait_done(250, "backpressure");
    chk("bp_stall_used", stall_left, 0);
    chk("bp_count", rx_cnt, 8);
    stall_win = -1;

    // Degenerate width.
    pulse_start(0, 4, 9, 1);
    wait_done(2, "degenerate");
    chk("degenerate_count", rx_cnt, 0);

    // Exact fit, also clears err.
    pulse_start(0, 5, 5, 1);
    wait_done(50, "exact");
    chk("exact_count", rx_cnt, 1);

    // Reset while fetching row r=2.
    pulse_start(100, 8, 6, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulse_start(100, 8, 6, 1);
    wait_done(200, "after_reset");
    chk("after_reset_count", rx_cnt, 8);

    // Start while busy is ignored.
    pulse_start(100, 8, 6, 1);
    repeat (7) @(posedge clk);
    pulse_start(500, 9, 9, 0);
    wait_done(200, "start_busy");
    chk("start_busy_count", rx_cnt, 8);

    // Random frames with random backpressure.
    ready_mode = 1;
    for (int i = 0; i < 8; i++) begin
      w    = $urandom_range(3, 10);
      h    = $urandom_range(3, 8);
      base = $urandom_range(0, 65535);
      pulse_start(base, w, h, 1);
      wait_done(60 + n_windows(w, h) * (K + 1) * 4, "random");
      chk("random_count", rx_cnt, n_windows(w, h));
    end
    ready_mode = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
